// File: rtl/tmc_uart_pkg.sv
// Shared constants and types for the TMC single-wire UART master.
// Holds the frame constants (sync nibble, reply address, CRC polynomial),
// frame lengths, the controller state encoding and a one-bit CRC step helper.
package tmc_uart_pkg;

  localparam logic [7:0] SyncByte  = 8'h05;
  localparam logic [7:0] ReplyAddr = 8'hFF;
  localparam logic [7:0] CrcPoly   = 8'h07;

  // Frame geometry, counted in bytes (TX/RX) and bit times (gap).
  localparam int unsigned WrBytes    = 8;
  localparam int unsigned RdBytes    = 4;
  localparam int unsigned ReplyBytes = 8;
  localparam int unsigned GapBits    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StRxWait,
    StRx,
    StGap
  } state_e;

  // One bit of CRC-8, data fed LSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return (crc[7] ^ b) ? ((crc << 1) ^ CrcPoly) : (crc << 1);
  endfunction

endpackage

// File: rtl/tmc_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00) shared by the TX and RX paths.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : return the CRC to its initial value (wins over en)
//   en       : fold bit_in into the CRC this cycle
//   bit_in   : data bit, LSB of each byte first
//   crc      : current CRC value
module tmc_crc8
  import tmc_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/tmc_uart.sv
// Single-wire UART master for TMC stepper drivers: sends a write frame or a
// read request, then for reads receives and CRC-checks the 8-byte reply.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request strobe, accepted only while busy=0
//   is_write            : 1 = write frame, 0 = read request
//   slave, regaddr      : node address and register
//   wdata               : write value
//   busy                : transaction in progress (through the done cycle)
//   done                : one-cycle completion pulse
//   rdata               : last read value with a good CRC
//   crc_err, frame_err  : reply CRC mismatch / reply stop bit sampled low
//   timeout             : no reply start bit seen
//   uart_in             : line level (asynchronous)
//   uart_out, uart_en   : drive value and output enable for the shared pin
module tmc_uart
  import tmc_uart_pkg::*;
#(
  parameter int unsigned HZ           = 48000000,
  parameter int unsigned BAUD         = 250000,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_write,
  input  logic [7:0]  slave,
  input  logic [6:0]  regaddr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout,
  input  logic        uart_in,
  output logic        uart_out,
  output logic        uart_en
);

  localparam int unsigned Div        = HZ / BAUD;
  localparam int unsigned TimeoutCyc = TIMEOUT_BITS * Div;
  localparam int unsigned GapCyc     = GapBits * Div;
  localparam int unsigned CntMax     = (TimeoutCyc > GapCyc) ? TimeoutCyc : GapCyc;
  localparam int unsigned CntW       = $clog2(CntMax);

  localparam logic [CntW-1:0] BitEnd     = CntW'(Div - 1);
  localparam logic [CntW-1:0] BitMid     = CntW'(Div / 2);
  localparam logic [CntW-1:0] TimeoutEnd = CntW'(TimeoutCyc - 1);
  localparam logic [CntW-1:0] GapEnd     = CntW'(GapCyc - 1);
  localparam logic [2:0]      RxLast     = 3'(ReplyBytes - 1);

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;    // 0 = start, 1..8 = data, 9 = stop
  logic [2:0] byte_q, byte_d;
  logic wr_q, wr_d;
  logic [7:0] slave_q, slave_d;
  logic [6:0] reg_q, reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic crc_err_q, crc_err_d;
  logic frame_err_q, frame_err_d;
  logic timeout_q, timeout_d;
  logic [2:0] sync_q;          // [0],[1] synchronizer, [2] previous for edge detect

  logic crc_clr, crc_en, crc_bit;
  logic [7:0] crc;
  logic [7:0] tx_byte;
  logic tx_bit;
  logic [2:0] tx_last;
  logic [2:0] data_idx;
  logic is_data_bit;
  logic rx_line, rx_fall;

  tmc_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  assign rx_line     = sync_q[1];
  assign rx_fall     = sync_q[2] & ~sync_q[1];
  assign tx_last     = wr_q ? 3'(WrBytes - 1) : 3'(RdBytes - 1);
  assign data_idx    = 3'(bit_q - 4'd1);
  assign is_data_bit = (bit_q != 4'd0) && (bit_q != 4'd9);

  // The last request byte is always the running CRC.
  always_comb begin
    case (byte_q)
      3'd0:    tx_byte = SyncByte;
      3'd1:    tx_byte = slave_q;
      3'd2:    tx_byte = {wr_q, reg_q};
      3'd3:    tx_byte = wdata_q[31:24];
      3'd4:    tx_byte = wdata_q[23:16];
      3'd5:    tx_byte = wdata_q[15:8];
      3'd6:    tx_byte = wdata_q[7:0];
      default: tx_byte = crc;
    endcase
    if (byte_q == tx_last) begin
      tx_byte = crc;
    end
  end

  always_comb begin
    if (bit_q == 4'd0) begin
      tx_bit = 1'b0;
    end else if (bit_q == 4'd9) begin
      tx_bit = 1'b1;
    end else begin
      tx_bit = tx_byte[data_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    wr_d        = wr_q;
    slave_d     = slave_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rdata_d     = rdata_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StTx;
          cnt_d       = '0;
          bit_d       = '0;
          byte_d      = '0;
          wr_d        = is_write;
          slave_d     = slave;
          reg_d       = regaddr;
          wdata_d     = wdata;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
          timeout_d   = 1'b0;
          crc_clr     = 1'b1;
        end
      end

      StTx: begin
        // Fold each payload bit into the CRC as its bit time begins, so the
        // CRC is complete before the final byte is selected for sending.
        crc_bit = tx_byte[data_idx];
        crc_en  = (cnt_q == '0) && is_data_bit && (byte_q != tx_last);
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (byte_q == tx_last) begin
              byte_d = '0;
              if (wr_q) begin
                state_d = StGap;
              end else begin
                state_d = StRxWait;
                crc_clr = 1'b1;
              end
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRxWait: begin
        if (rx_fall) begin
          // The detect cycle is cycle 0 of the start bit.
          state_d = StRx;
          cnt_d   = CntW'(1);
          bit_d   = '0;
          byte_d  = '0;
        end else if (cnt_q == TimeoutEnd) begin
          timeout_d = 1'b1;
          state_d   = StGap;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRx: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            bit_d  = '0;
            byte_d = byte_q + 3'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end

        if (cnt_q == BitMid) begin
          if (is_data_bit) begin
            rx_shift_d = {rx_line, rx_shift_q[7:1]};
            crc_en     = (byte_q != RxLast);
            crc_bit    = rx_line;
          end else if (bit_q == 4'd9) begin
            if (!rx_line) begin
              frame_err_d = 1'b1;
            end
            if (byte_q >= 3'd3 && byte_q <= 3'd6) begin
              rx_data_d = {rx_data_q[23:0], rx_shift_q};
            end
            if (byte_q == RxLast) begin
              if (rx_shift_q == crc) begin
                rdata_d = rx_data_q;
              end else begin
                crc_err_d = 1'b1;
              end
              state_d = StGap;
              cnt_d   = '0;
            end
          end
        end
      end

      StGap: begin
        if (cnt_q == GapEnd) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      wr_q        <= 1'b0;
      slave_q     <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rdata_q     <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      sync_q      <= 3'b111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      wr_q        <= wr_d;
      slave_q     <= slave_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rdata_q     <= rdata_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      sync_q      <= {sync_q[1:0], uart_in};
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StGap) && (cnt_q == GapEnd);
  assign rdata     = rdata_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
  assign uart_en   = (state_q == StTx);
  assign uart_out  = uart_en ? tx_bit : 1'b1;

endmodule

// File: tb/tb_tmc_uart.sv
`timescale 1ns/1ps
module tb_tmc_uart;

  localparam int unsigned HZ   = 1600000;
  localparam int unsigned BAUD = 100000;
  localparam int unsigned DIV  = HZ / BAUD;
  localparam int unsigned TOB  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_write = 1'b0;
  logic [7:0]  slave = '0;
  logic [6:0]  regaddr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, crc_err, frame_err, timeout;
  logic [31:0] rdata;
  logic        uart_in, uart_out, uart_en;
  logic        tb_drv = 1'b1;

  // Single wire: while the DUT drives, it hears its own echo.
  assign uart_in = uart_en ? uart_out : tb_drv;

  always #5 clk = ~clk;

  tmc_uart #(
    .HZ           (HZ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_write  (is_write),
    .slave     (slave),
    .regaddr   (regaddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .timeout   (timeout),
    .uart_in   (uart_in),
    .uart_out  (uart_out),
    .uart_en   (uart_en)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int en_cycles = 0;
  int last_en_len = 0;
  int mon_pos, mon_bit;
  logic [7:0] mon_shift = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[7] ^ b[i]) ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Line monitor: decodes driven bytes at mid-bit and pops the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (uart_en) begin
      mon_pos = en_cycles % (10 * DIV);
      if (mon_pos % DIV == DIV / 2) begin
        mon_bit = mon_pos / DIV;
        if (mon_bit == 0) begin
          check("start_bit", 32'(uart_out), 32'd0);
        end else if (mon_bit <= 8) begin
          mon_shift = {uart_out, mon_shift[7:1]};
        end else begin
          check("stop_bit", 32'(uart_out), 32'd1);
          check("tx_byte", 32'(mon_shift), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100);
        end
      end
      en_cycles++;
    end else begin
      if (en_cycles != 0) last_en_len = en_cycles;
      en_cycles = 0;
      check("idle_line_high", 32'(uart_out), 32'd1);
    end
  end

  task automatic push_req(input logic w, input logic [7:0] s, input logic [6:0] r,
                          input logic [31:0] d);
    logic [7:0] b[8];
    logic [7:0] c;
    int n;
    b[0] = 8'h05; b[1] = s; b[2] = {w, r};
    b[3] = d[31:24]; b[4] = d[23:16]; b[5] = d[15:8]; b[6] = d[7:0];
    n = w ? 7 : 3;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = crc_upd(c, b[i]);
      exp_q.push_back(b[i]);
    end
    exp_q.push_back(c);
  endtask

  task automatic launch(input logic w, input logic [7:0] s, input logic [6:0] r,
                        input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; is_write = w; slave = s; regaddr = r; wdata = d;
    @(posedge clk);
    #1;
    start = 1'b0; is_write = ~w; slave = ~s; regaddr = ~r; wdata = ~d;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300 * DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check("done_single_cycle", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    tb_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_drv = b[i];
      repeat (DIV) @(negedge clk);
    end
    tb_drv = stop;
    repeat (DIV) @(negedge clk);
    tb_drv = 1'b1;
  endtask

  task automatic send_reply(input logic [31:0] d, input logic corrupt, input int bad_stop);
    logic [7:0] r[8];
    logic [7:0] c;
    r[0] = 8'h05; r[1] = 8'hFF; r[2] = 8'h00;
    r[3] = d[31:24]; r[4] = d[23:16]; r[5] = d[15:8]; r[6] = d[7:0];
    c = 8'h00;
    for (int i = 0; i < 7; i++) c = crc_upd(c, r[i]);
    r[7] = corrupt ? ~c : c;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send_byte(r[i], (i != bad_stop));
  endtask

  initial begin
    int n;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_crc_err", 32'(crc_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_uart_en", 32'(uart_en), 32'd0);
    check("rst_uart_out", 32'(uart_out), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read slave 0 reg 0, nobody answers: fixed request bytes, then timeout
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h48);
    dc = done_cnt;
    launch(1'b0, 8'h00, 7'h00, 32'h0);
    wait_done(n);
    check("timeout_done_latency", n, (40 + TOB + 4) * DIV - 1);
    check("read_en_len", last_en_len, 40 * DIV);
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_crc_err", 32'(crc_err), 32'd0);
    check("timeout_rdata", rdata, 32'd0);
    check("req_bytes_sent", exp_q.size(), 0);
    check("timeout_done_pulses", done_cnt - dc, 1);

    // Read with a good reply
    push_req(1'b0, 8'h00, 7'h00, 32'h0);
    dc = done_cnt;
    launch(1'b0, 8'h00, 7'h00, 32'h0);
    check("timeout_cleared", 32'(timeout), 32'd0);
    repeat (42 * DIV) @(negedge clk);
    send_reply(32'h0000_0140, 1'b0, -1);
    wait_done(n);
    check("good_rdata", rdata, 32'h0000_0140);
    check("good_crc_err", 32'(crc_err), 32'd0);
    check("good_frame_err", 32'(frame_err), 32'd0);
    check("good_timeout", 32'(timeout), 32'd0);
    check("good_done_pulses", done_cnt - dc, 1);

    // Same reply, CRC byte inverted
    push_req(1'b0, 8'h00, 7'h00, 32'h0);
    dc = done_cnt;
    launch(1'b0, 8'h00, 7'h00, 32'h0);
    repeat (42 * DIV) @(negedge clk);
    send_reply(32'h0000_0140, 1'b1, -1);
    wait_done(n);
    check("bad_crc_err", 32'(crc_err), 32'd1);
    check("bad_crc_rdata_held", rdata, 32'h0000_0140);
    check("bad_crc_done_pulses", done_cnt - dc, 1);

    // Good CRC but one low stop bit: flag it, still take the data
    push_req(1'b0, 8'h2A, 7'h6C, 32'h0);
    launch(1'b0, 8'h2A, 7'h6C, 32'h0);
    check("crc_err_cleared", 32'(crc_err), 32'd0);
    repeat (42 * DIV) @(negedge clk);
    send_reply(32'hDEAD_BEEF, 1'b0, 2);
    wait_done(n);
    check("stop_frame_err", 32'(frame_err), 32'd1);
    check("stop_crc_err", 32'(crc_err), 32'd0);
    check("stop_rdata", rdata, 32'hDEAD_BEEF);

    // Write with a start pulse mid-frame that must be ignored
    push_req(1'b1, 8'h00, 7'h10, 32'h0007_1F10);
    dc = done_cnt;
    launch(1'b1, 8'h00, 7'h10, 32'h0007_1F10);
    check("frame_err_cleared", 32'(frame_err), 32'd0);
    repeat (30 * DIV) @(negedge clk);
    start = 1'b1; is_write = 1'b0; slave = 8'h55; regaddr = 7'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("write_en_len", last_en_len, 80 * DIV);
    check("write_bytes_sent", exp_q.size(), 0);
    check("write_done_pulses", done_cnt - dc, 1);
    check("write_rdata_held", rdata, 32'hDEAD_BEEF);

    // Reset mid-byte aborts the write and releases the line at once
    push_req(1'b1, 8'h03, 7'h45, 32'h1234_5678);
    launch(1'b1, 8'h03, 7'h45, 32'h1234_5678);
    repeat (25 * DIV + 5) @(negedge clk);
    check("pre_rst_uart_en", 32'(uart_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_uart_en", 32'(uart_en), 32'd0);
    check("abort_uart_out", 32'(uart_out), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dc = done_cnt;
    repeat (100 * DIV) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmc_uart.md
TMC_UART -- requirements
Module: tmc_uart

Interface
REQ-001 SHALL have parameter HZ, default 48000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 250000, bit rate on the driver line; DIV = HZ/BAUD cycles per bit (192 at defaults).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 64, maximum bit times to wait for a reply start bit.
REQ-004 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: start  in  1  request strobe; is_write  in  1  1=write, 0=read; slave  in  8  node address; regaddr  in  7  register; wdata  in  32  write value.
REQ-006 SHALL have ports: busy  out  1  transaction active; done  out  1  one-cycle completion pulse; rdata  out  32  read value; crc_err  out  1  reply CRC mismatch; frame_err  out  1  reply stop bit low; timeout  out  1  no reply.
REQ-007 SHALL have ports: uart_in  in  1  line level; uart_out  out  1  line drive value; uart_en  out  1  output enable for the tri-state single-wire pin.

Function
REQ-008 SHALL accept start only when busy=0; start while busy SHALL be ignored; inputs are sampled at the accepted start cycle.
REQ-009 SHALL raise busy the cycle after an accepted start and hold it until the cycle done pulses.
REQ-010 Write frame SHALL be 8 bytes: 0x05, slave, {1,regaddr}, wdata[31:24], [23:16], [15:8], [7:0], CRC.
REQ-011 Read request SHALL be 4 bytes: 0x05, slave, {0,regaddr}, CRC.
REQ-012 CRC SHALL be CRC-8 poly 0x07, init 0x00, bytes fed LSB first: per bit, crc = (crc[7]^bit) ? (crc<<1)^0x07 : crc<<1.
REQ-013 Each byte SHALL be sent as start bit 0, 8 data bits LSB first, stop bit 1, each exactly DIV cycles, with no gap between bytes.
REQ-014 uart_en SHALL be 1 from first start bit until the end of the last stop bit, otherwise 0; uart_out SHALL be 1 whenever uart_en=0.
REQ-015 FSM states SHALL be IDLE, TX, RX_WAIT, RX, GAP; IDLE->TX on accepted start; TX->GAP after last byte of a write; TX->RX_WAIT after last byte of a read.
REQ-016 uart_in SHALL pass through a 2-FF synchronizer; RX_WAIT SHALL detect a falling edge as start bit; no edge within TIMEOUT_BITS*DIV cycles SHALL set timeout and go to GAP.
REQ-017 RX SHALL sample each bit at DIV/2 cycles into the bit, receive 8 bytes, and SHALL set frame_err if any stop bit samples 0 (remaining bytes still received).
REQ-018 Reply SHALL be 0x05, 0xFF, reg, 4 data bytes MSB-first, CRC; rdata SHALL update only when CRC is correct, else crc_err=1 and rdata holds its previous value.
REQ-019 GAP SHALL keep the line released for 4 bit times, then pulse done for one cycle and return to IDLE.
REQ-020 crc_err, frame_err, timeout SHALL clear on the accepted start of the next transaction and hold otherwise.
REQ-021 Bytes arriving on uart_in while uart_en=1 (own echo) SHALL be ignored.

Reset
REQ-022 rst SHALL force IDLE, busy=0, done=0, rdata=0, all error flags 0, uart_en=0, uart_out=1 on the next clock edge.
REQ-023 rst asserted mid-transaction SHALL abort it with no done pulse and release the line within one cycle.

Structure
REQ-024 Frame constants (sync 0x05, reply address 0xFF, poly 0x07, state encoding) SHALL live in a shared package tmc_uart_pkg.
REQ-025 CRC update SHALL be one sub-module, tmc_crc8 (bit-serial, clear/enable/bit inputs, 8-bit output), instantiated once and shared by TX and RX.

Verification
REQ-026 Read slave=0x00 reg=0x00 -> line carries 0x05,0x00,0x00,0x48; uart_en high exactly 40*DIV cycles.
REQ-027 Read with bench model replying 0x05,0xFF,0x00,0x00,0x00,0x01,0x40,CRC -> rdata=0x00000140, crc_err=0, done one pulse.
REQ-028 Same reply with CRC byte inverted -> crc_err=1, rdata unchanged, done pulses.
REQ-029 Read with no reply -> timeout=1 and done after 64 bit times of RX_WAIT plus 4 GAP bit times.
REQ-030 Write slave=0x00 reg=0x10 wdata=0x00071F10 -> 8 bytes with third byte 0x90 and correct CRC; start pulsed mid-frame is ignored; rst mid-byte -> uart_en=0, uart_out=1 next cycle, no done.
